// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester and divider signals of the shared divider arbiter.
// master = arbiter side, slave = requesters plus divider side.
interface div_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] dvd0;
  logic [31:0] dvd1;
  logic [15:0] dvs0;
  logic [15:0] dvs1;
  logic        sgn0;
  logic        sgn1;
  logic        done0;
  logic        done1;
  logic [15:0] quot;
  logic [15:0] rem;
  logic [1:0]  err;
  logic        busy;
  logic [31:0] div_denom;
  logic [15:0] div_num;
  logic        div_signed;
  logic        div_run_in;
  logic        div_run_out;
  logic [15:0] div_q;
  logic [15:0] div_r;

  modport master (
    input  req0, req1, dvd0, dvd1,
    input  dvs0, dvs1, sgn0, sgn1,
    output done0, done1, quot, rem,
    output err, busy,
    output div_denom, div_num,
    output div_signed, div_run_in,
    input  div_run_out, div_q, div_r
  );

  modport slave (
    output req0, req1, dvd0, dvd1,
    output dvs0, dvs1, sgn0, sgn1,
    input  done0, done1, quot, rem,
    input  err, busy,
    input  div_denom, div_num,
    input  div_signed, div_run_in,
    output div_run_out, div_q, div_r
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative 32/16 divider between two requesters,
// with overflow/zero pre-check, remainder sign fix-up and a watchdog.
module div_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 24
) (
  input logic          clk,
  input logic          reset,
  div_arbiter_if.master bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic           owner;
  logic           last_grant;
  logic [WDW-1:0] wd;
  logic [31:0]    denom;
  logic [15:0]    num;
  logic           sgn;
  logic           run_in;
  logic           done0_q;
  logic           done1_q;
  logic [15:0]    quot_q;
  logic [15:0]    rem_q;
  logic [1:0]     err_q;

  logic        grant_go;
  logic        grant_sel;
  logic        chk_fail;
  logic        go;
  logic        fin;
  logic        abort;

  logic [31:0] abs_a;
  logic [15:0] abs_b;
  logic [32:0] lim;
  logic        sgn_diff;
  logic        dz;
  logic        ovf;
  logic [15:0] rem_fix;

  // Magnitude test: a negative quotient may reach -32768, a positive one 32767.
  always_comb begin
    abs_a    = denom[31] ? (~denom + 32'd1) : denom;
    abs_b    = num[15] ? (~num + 16'd1) : num;
    sgn_diff = denom[31] ^ num[15];
    lim      = {2'b00, abs_b, 15'd0};
    if (sgn_diff)
      lim = lim + {17'd0, abs_b};
    dz = (num == 16'd0);
    if (sgn)
      ovf = ({1'b0, abs_a} >= lim);
    else
      ovf = (denom[31:16] >= num);
  end

  // The divider signs its remainder like the quotient; fold back to dividend sign.
  assign rem_fix = (sgn && num[15]) ?
                   (~bus.div_r + 16'd1) : bus.div_r;

  always_comb begin
    state_n   = state;
    grant_go  = 1'b0;
    grant_sel = 1'b0;
    chk_fail  = 1'b0;
    go        = 1'b0;
    fin       = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_go = 1'b1;
          state_n  = LOAD;
          if (bus.req0 && bus.req1)
            grant_sel = ROUND_ROBIN ? ~last_grant : 1'b0;
          else
            grant_sel = bus.req1;
        end
      end
      LOAD: begin
        if (dz || ovf) begin
          chk_fail = 1'b1;
          state_n  = DONE;
        end else begin
          go      = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.div_run_out == run_in) begin
          fin     = 1'b1;
          state_n = DONE;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wd         <= '0;
      denom      <= '0;
      num        <= '0;
      sgn        <= 1'b0;
      run_in     <= bus.div_run_out;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 2'd0;
    end else begin
      state   <= state_n;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (grant_go) begin
        owner      <= grant_sel;
        last_grant <= grant_sel;
        denom      <= grant_sel ? bus.dvd1 : bus.dvd0;
        num        <= grant_sel ? bus.dvs1 : bus.dvs0;
        sgn        <= grant_sel ? bus.sgn1 : bus.sgn0;
      end
      if (go) begin
        run_in <= ~run_in;
        wd     <= '0;
      end
      if (state == RUN)
        wd <= wd + WDW'(1);
      if (chk_fail) begin
        quot_q <= '0;
        rem_q  <= '0;
        err_q  <= dz ? 2'd1 : 2'd2;
      end
      if (fin) begin
        quot_q <= bus.div_q;
        rem_q  <= rem_fix;
        err_q  <= 2'd0;
      end
      if (abort) begin
        run_in <= bus.div_run_out;
        quot_q <= '0;
        rem_q  <= '0;
        err_q  <= 2'd3;
      end
      if (chk_fail || fin || abort) begin
        done0_q <= ~owner;
        done1_q <= owner;
      end
    end
  end

  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.quot       = quot_q;
  assign bus.rem        = rem_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state != IDLE);
  assign bus.div_denom  = denom;
  assign bus.div_num    = num;
  assign bus.div_signed = sgn;
  assign bus.div_run_in = run_in;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed checks of div_arbiter with a behavioural
// 17-edge toggle-handshake divider attached to each instance.
module tb_div_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_arbiter_if bus();
  div_arbiter_if bus1();

  div_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(24)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  div_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(24)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;
  bit stuck  = 1'b0;
  bit div_rst = 1'b1;
  int cnt0;
  int cnt1;

  // Divider result: remainder carries the quotient's sign.
  function automatic logic [31:0] divmodel(
    input logic [31:0] d, input logic [15:0] n, input logic s);
    logic [31:0] a, b, qa, ra;
    logic neg;
    if (n == 16'd0) return 32'd0;
    if (!s) begin
      qa = d / {16'd0, n};
      ra = d % {16'd0, n};
      return {qa[15:0], ra[15:0]};
    end
    a   = d[31] ? -d : d;
    b   = n[15] ? -{16'hFFFF, n} : {16'd0, n};
    qa  = a / b;
    ra  = a % b;
    neg = d[31] ^ n[15];
    if (neg) begin
      qa = -qa;
      ra = -ra;
    end
    return {qa[15:0], ra[15:0]};
  endfunction

  always @(posedge clk) begin
    if (div_rst) begin
      bus.div_run_out <= 1'b0;
      bus.div_q <= '0;
      bus.div_r <= '0;
      cnt0 <= 0;
    end else if (stuck || bus.div_run_in == bus.div_run_out) begin
      cnt0 <= 0;
    end else if (cnt0 == 16) begin
      bus.div_run_out <= bus.div_run_in;
      {bus.div_q, bus.div_r} <=
        divmodel(bus.div_denom, bus.div_num, bus.div_signed);
      cnt0 <= 0;
    end else begin
      cnt0 <= cnt0 + 1;
    end
  end

  always @(posedge clk) begin
    if (div_rst) begin
      bus1.div_run_out <= 1'b0;
      bus1.div_q <= '0;
      bus1.div_r <= '0;
      cnt1 <= 0;
    end else if (bus1.div_run_in == bus1.div_run_out) begin
      cnt1 <= 0;
    end else if (cnt1 == 16) begin
      bus1.div_run_out <= bus1.div_run_in;
      {bus1.div_q, bus1.div_r} <=
        divmodel(bus1.div_denom, bus1.div_num, bus1.div_signed);
      cnt1 <= 0;
    end else begin
      cnt1 <= cnt1 + 1;
    end
  end

  task automatic run_op(input bit who, input logic [31:0] d,
                        input logic [15:0] n, input bit s,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic [1:0] ee, input int elat,
                        input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    if (who) begin
      bus.req1 = 1'b1; bus.dvd1 = d; bus.dvs1 = n; bus.sgn1 = s;
    end else begin
      bus.req0 = 1'b1; bus.dvd0 = d; bus.dvs0 = n; bus.sgn0 = s;
    end
    lat = -1;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (who ? bus.done1 : bus.done0) begin
        seen = 1'b1;
        lat = k;
      end
    end
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, elat);
    end
    checks++;
    if (bus.quot !== eq) begin
      errors++;
      $display("FAIL %s quot: got %h want %h", nm, bus.quot, eq);
    end
    checks++;
    if (bus.rem !== er) begin
      errors++;
      $display("FAIL %s rem: got %h want %h", nm, bus.rem, er);
    end
    checks++;
    if (bus.err !== ee) begin
      errors++;
      $display("FAIL %s err: got %0d want %0d", nm, bus.err, ee);
    end
    checks++;
    if ((who ? bus.done0 : bus.done1) !== 1'b0) begin
      errors++;
      $display("FAIL %s other_done: got 1 want 0", nm);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit seen;
    int lat;
    reset = 1'b1;
    div_rst = 1'b1;
    repeat (3) @(negedge clk);
    div_rst = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done0, bus.done1} !== 2'b00) begin
      errors++;
      $display("FAIL reset done: got %b want 00", {bus.done0, bus.done1});
    end
    checks++;
    if ({bus.quot, bus.rem} !== 32'd0) begin
      errors++;
      $display("FAIL reset quot_rem: got %h want 0", {bus.quot, bus.rem});
    end
    checks++;
    if (bus.err !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset err_busy: got %0d/%b want 0/0", bus.err, bus.busy);
    end
    checks++;
    if (bus.div_run_in !== bus.div_run_out) begin
      errors++;
      $display("FAIL reset handshake: got %b/%b want equal",
               bus.div_run_in, bus.div_run_out);
    end
    // after reset last_grant is 1, so contention goes to requester 0
    bus.dvd0 = 32'd5; bus.dvs0 = 16'd0; bus.sgn0 = 1'b0;
    bus.dvd1 = 32'd5; bus.dvs1 = 16'd0; bus.sgn1 = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    seen = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        lat = k;
      end
    end
    checks++;
    if (!bus.done0 || bus.done1 || lat !== 1) begin
      errors++;
      $display("FAIL first_grant: got done0=%b done1=%b lat=%0d want 1 0 1",
               bus.done0, bus.done1, lat);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    run_op(0, 32'd100000, 16'd7, 0, 16'd14285, 16'd5, 2'd0, 19, "t1_u");
    run_op(1, 32'd1000, 16'd10, 0, 16'd100, 16'd0, 2'd0, 19, "t1_u_r1");
  endtask

  task automatic test_signed();
    run_op(0, 32'hFFFFFFF9, 16'd2, 1, 16'hFFFD, 16'hFFFF, 2'd0, 19, "t2_neg");
    run_op(1, 32'd7, 16'hFFFE, 1, 16'hFFFD, 16'h0001, 2'd0, 19, "t2_nden");
  endtask

  task automatic test_precheck();
    logic ri;
    ri = bus.div_run_in;
    run_op(1, 32'd1234, 16'd0, 0, 16'd0, 16'd0, 2'd1, 1, "t3_dz");
    checks++;
    if (bus.div_run_in !== ri) begin
      errors++;
      $display("FAIL t3_dz run_in: got %b want %b", bus.div_run_in, ri);
    end
    run_op(0, 32'h00070000, 16'd7, 0, 16'd0, 16'd0, 2'd2, 1, "t3_uovf");
    run_op(0, 32'h80000000, 16'hFFFF, 1, 16'd0, 16'd0, 2'd2, 1, "t4_min");
    run_op(0, 32'hFFFF0000, 16'd2, 1, 16'h8000, 16'd0, 2'd0, 19, "t4_edge");
    run_op(1, 32'h00010000, 16'd2, 1, 16'd0, 16'd0, 2'd2, 1, "t4_povf");
  endtask

  task automatic test_back_to_back();
    bit seen;
    bit g;
    int tick;
    int prev;
    run_op(0, 32'd50, 16'd5, 0, 16'd10, 16'd0, 2'd0, 19, "t5_pre");
    @(negedge clk);
    bus.dvd0 = 32'd100000; bus.dvs0 = 16'd7; bus.sgn0 = 1'b0;
    bus.dvd1 = 32'd1000; bus.dvs1 = 16'd10; bus.sgn1 = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick = 0;
    prev = 0;
    for (int c = 0; c < 4; c++) begin
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        tick++;
        if (bus.done0 || bus.done1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rr_wait %0d: got no done want done", c);
      end
      checks++;
      if (bus.done0 && bus.done1) begin
        errors++;
        $display("FAIL rr_overlap %0d: got both dones want one", c);
      end
      g = bus.done1;
      checks++;
      if (g !== ((c % 2) == 0)) begin
        errors++;
        $display("FAIL rr_grant %0d: got %b want %b", c, g, (c % 2) == 0);
      end
      checks++;
      if (bus.quot !== (g ? 16'd100 : 16'd14285)) begin
        errors++;
        $display("FAIL rr_quot %0d: got %0d want %0d", c, bus.quot,
                 g ? 100 : 14285);
      end
      if (c > 0) begin
        checks++;
        if (tick - prev !== 21) begin
          errors++;
          $display("FAIL rr_gap %0d: got %0d want 21", c, tick - prev);
        end
      end
      prev = tick;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    bit seen;
    bit any1;
    @(negedge clk);
    bus1.dvd0 = 32'd100000; bus1.dvs0 = 16'd7; bus1.sgn0 = 1'b0;
    bus1.dvd1 = 32'd1000; bus1.dvs1 = 16'd10; bus1.sgn1 = 1'b0;
    bus1.req0 = 1'b1;
    bus1.req1 = 1'b1;
    any1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (bus1.done1) any1 = 1'b1;
        if (bus1.done0 || bus1.done1) seen = 1'b1;
      end
      checks++;
      if (!bus1.done0 || bus1.quot !== 16'd14285) begin
        errors++;
        $display("FAIL fp_grant %0d: got done0=%b quot=%0d want 1 14285",
                 c, bus1.done0, bus1.quot);
      end
    end
    checks++;
    if (any1) begin
      errors++;
      $display("FAIL fp_starve: got done1 want none");
    end
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    bus.req0 = 1'b1; bus.dvd0 = 32'd100000;
    bus.dvs0 = 16'd7; bus.sgn0 = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.div_run_in === bus.div_run_out || !bus.busy) begin
      errors++;
      $display("FAIL midrun_running: got busy=%b want running", bus.busy);
    end
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_run_in !== bus.div_run_out || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got in=%b out=%b busy=%b want equal, 0",
               bus.div_run_in, bus.div_run_out, bus.busy);
    end
    run_op(0, 32'd1000, 16'd10, 0, 16'd100, 16'd0, 2'd0, 19, "t6_after");
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    run_op(0, 32'd1000, 16'd10, 0, 16'd0, 16'd0, 2'd3, 25, "t6_wdog");
    checks++;
    if (bus.div_run_in !== bus.div_run_out) begin
      errors++;
      $display("FAIL wdog_abort: got %b/%b want equal",
               bus.div_run_in, bus.div_run_out);
    end
    stuck = 1'b0;
    run_op(1, 32'd81, 16'd9, 0, 16'd9, 16'd0, 2'd0, 19, "t6_recover");
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.dvd0 = '0; bus.dvd1 = '0;
    bus.dvs0 = '0; bus.dvs1 = '0;
    bus.sgn0 = 1'b0; bus.sgn1 = 1'b0;
    bus1.req0 = 1'b0; bus1.req1 = 1'b0;
    bus1.dvd0 = '0; bus1.dvd1 = '0;
    bus1.dvs0 = '0; bus1.dvs1 = '0;
    bus1.sgn0 = 1'b0; bus1.sgn1 = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_precheck();
    test_back_to_back();
    test_fixed_priority();
    test_reset_midrun();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
